// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: run/stop/lap/clear sequencing with a double-click
// window on the run button.
module stopwatch_cu #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned DCLICK_MS = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_run,
    input  logic       i_btn_clear,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_lap,
    output logic [1:0] o_state
);

    localparam int unsigned WIN    = (CLK_HZ / 1000) * DCLICK_MS;
    localparam int unsigned WCNT_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WIN - 1);

    typedef enum logic [1:0] {
        STOP     = 2'b00,
        RUN      = 2'b01,
        RUN_WAIT = 2'b11,
        CLEAR    = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              lap_q, lap_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STOP;
            wcnt_q  <= '0;
            lap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            lap_q   <= lap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        lap_d   = lap_q;
        case (state_q)
            STOP: begin
                if (i_btn_clear)    state_d = CLEAR;
                else if (i_btn_run) state_d = RUN;
            end
            RUN: begin
                if (i_btn_run) begin
                    state_d = RUN_WAIT;
                    wcnt_d  = '0;
                end
            end
            RUN_WAIT: begin
                // A second press wins even on the last window cycle; the
                // counter stops at WCNT_LAST so it can never wrap.
                if (i_btn_run) begin
                    state_d = RUN;
                    lap_d   = ~lap_q;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d = STOP;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            CLEAR:   state_d = STOP;
            default: state_d = STOP;
        endcase
        if (state_d == STOP || state_d == CLEAR) lap_d = 1'b0;
    end

    assign o_state = state_q;
    assign o_run   = (state_q == RUN) || (state_q == RUN_WAIT);
    assign o_clear = (state_q == CLEAR);
    assign o_lap   = lap_q;

endmodule

// File: tb/tb_stopwatch_cu.sv
// Directed bench for stopwatch_cu with WIN = 30 cycles.
module tb_stopwatch_cu;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_btn_run = 1'b0;
    logic       i_btn_clear = 1'b0;
    logic       o_run, o_clear, o_lap;
    logic [1:0] o_state;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    stopwatch_cu #(.CLK_HZ(10_000), .DCLICK_MS(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_btn_run   (i_btn_run),
        .i_btn_clear (i_btn_clear),
        .o_run       (o_run),
        .o_clear     (o_clear),
        .o_lap       (o_lap),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       clr;
        logic [1:0] st;
        logic       r;
        logic       c;
        logic       l;
    } vec_t;

    vec_t vecs[15];

    // Compares {state, run, clear, lap} as one value.
    task automatic check(input string name, input logic [1:0] st,
                         input logic r, input logic c, input logic l);
        logic [4:0] got, exp;
        got = {o_state, o_run, o_clear, o_lap};
        exp = {st, r, c, l};
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got st/run/clr/lap=%b required %b", name, got, exp);
    endtask

    task automatic step(input logic run, input logic clr);
        @(negedge clk);
        i_btn_run   = run;
        i_btn_clear = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1};

        #1 reset = 1'b1;
        #2 check("reset_async", 2'b00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].run, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].r, vecs[i].c, vecs[i].l);
        end

        // Pulses at t and t+10 toggle lap twice: 1 -> 0 -> 1.
        for (int rep = 0; rep < 2; rep++) begin
            step(1'b1, 1'b0);
            check($sformatf("dclk%0d_open", rep), 2'b11, 1'b1, 1'b0, rep == 1 ? 1'b0 : 1'b1);
            for (int k = 1; k <= 9; k++) begin
                step(1'b0, 1'b0);
                check($sformatf("dclk%0d_wait%0d", rep, k), 2'b11, 1'b1, 1'b0, rep == 1 ? 1'b0 : 1'b1);
            end
            step(1'b1, 1'b0);
            check($sformatf("dclk%0d_close", rep), 2'b01, 1'b1, 1'b0, rep == 1 ? 1'b1 : 1'b0);
        end

        // Single pulse with lap=1: 30 cycles of RUN_WAIT, then STOP with lap cleared.
        step(1'b1, 1'b0);
        check("exp_open", 2'b11, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 29; k++) begin
            step(1'b0, 1'b0);
            check($sformatf("exp_wait%0d", k), 2'b11, 1'b1, 1'b0, 1'b1);
        end
        step(1'b0, 1'b0);
        check("exp_stop", 2'b00, 1'b0, 1'b0, 1'b0);

        // Second press on the last window cycle still counts as a double click.
        step(1'b1, 1'b0);
        check("edge_run", 2'b01, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("edge_open", 2'b11, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 29; k++) step(1'b0, 1'b0);
        check("edge_last", 2'b11, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("edge_dclk", 2'b01, 1'b1, 1'b0, 1'b1);

        // One cycle too late: window expires, the late pulse restarts RUN.
        step(1'b1, 1'b0);
        check("late_open", 2'b11, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 29; k++) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("late_stop", 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("late_restart", 2'b01, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a window with lap=1.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("rst_lapset", 2'b01, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) step(1'b0, 1'b0);
        check("rst_inwin", 2'b11, 1'b1, 1'b0, 1'b1);
        #2;
        i_btn_run   = 1'b0;
        i_btn_clear = 1'b0;
        reset       = 1'b1;
        #1 check("rst_mid", 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0);
            check($sformatf("rst_idle%0d", k), 2'b00, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0);
        check("rst_fresh_run", 2'b01, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_cu.md
STOPWATCH_CU -- requirements
Module: stopwatch_cu

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter DCLICK_MS, default 300, meaning the double-click window in ms.
REQ-003 The block SHALL derive localparam WIN = (CLK_HZ/1000)*DCLICK_MS, meaning the window length in clk cycles; WIN SHALL be at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock, with all logic on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port i_btn_run, input, 1 bit: debounced single-cycle press pulse for run/stop/lap.
REQ-007 The block SHALL have port i_btn_clear, input, 1 bit: debounced single-cycle press pulse for clear.
REQ-008 The block SHALL have port o_run, output, 1 bit: level signal; 1 enables the stopwatch time counter.
REQ-009 The block SHALL have port o_clear, output, 1 bit: single-cycle pulse that zeroes the time counter.
REQ-010 The block SHALL have port o_lap, output, 1 bit: level signal; 1 freezes the display while counting continues.
REQ-011 The block SHALL have port o_state, output, 2 bits: current FSM state encoding.

Function
REQ-012 The FSM SHALL have four states: STOP=2'b00, RUN=2'b01, RUN_WAIT=2'b11, CLEAR=2'b10; o_state SHALL equal the state register.
REQ-013 All outputs SHALL be registered or decoded from registered state only, with no combinational path from input to output.
REQ-014 o_run SHALL be 1 exactly when the state is RUN or RUN_WAIT.
REQ-015 o_clear SHALL be 1 exactly when the state is CLEAR.
REQ-016 CLEAR SHALL last one cycle and then transition unconditionally to STOP.
REQ-017 In STOP, i_btn_clear=1 SHALL transition to CLEAR, taking priority over i_btn_run when both are 1 in the same cycle.
REQ-018 In STOP, i_btn_run=1 with i_btn_clear=0 SHALL transition to RUN.
REQ-019 In STOP, no pulse SHALL hold STOP.
REQ-020 In RUN, i_btn_run=1 SHALL transition to RUN_WAIT and load the window counter wcnt with 0.
REQ-021 In RUN, i_btn_clear SHALL be ignored.
REQ-022 In RUN_WAIT, wcnt SHALL increment by 1 per cycle; wcnt width SHALL be $clog2(WIN) and it SHALL never wrap.
REQ-023 In RUN_WAIT, i_btn_run=1 on any cycle (including the cycle where wcnt==WIN-1) SHALL be a double click: toggle o_lap and transition to RUN on the next edge.
REQ-024 In RUN_WAIT, wcnt==WIN-1 with i_btn_run=0 SHALL be a window expiry: transition to STOP on the next edge.
REQ-025 In RUN_WAIT, i_btn_clear SHALL be ignored.
REQ-026 Stop latency SHALL be fixed: a single run pulse in RUN at cycle t SHALL make o_run fall at edge t+WIN+1 when no second pulse arrives.
REQ-027 o_lap SHALL be forced to 0 on every transition into STOP or CLEAR and SHALL hold otherwise.
REQ-028 A run pulse after a double click SHALL be treated as a new first press that opens a fresh window.
REQ-029 Input pulses SHALL be consumed in the cycle they appear and SHALL not be queued.

Reset
REQ-030 On reset=1, independent of clk, the block SHALL set state=STOP, wcnt=0, o_run=0, o_clear=0, o_lap=0, o_state=2'b00.
REQ-031 Reset asserted mid-window (RUN_WAIT) SHALL abort the window, and the first edge after release SHALL evaluate from STOP.

Verification
(CLK_HZ=10_000, DCLICK_MS=3, so WIN=30.)
REQ-032 Single pulse in STOP SHALL give o_state 00->01 and o_run=1 one cycle later; a second single pulse at cycle t SHALL give o_state=11 over t+1..t+30, then 00, with o_run=0 from edge t+31.
REQ-033 From RUN, run pulses at t and t+10 SHALL give o_lap=1 and o_state=01 at t+11, with o_run remaining 1; the same pair again SHALL give o_lap=0.
REQ-034 A second pulse exactly at wcnt==29 SHALL toggle o_lap with o_state returning to 01; a pulse at wcnt==29 plus one cycle SHALL occur after STOP and restart RUN.
REQ-035 In STOP with i_btn_run=i_btn_clear=1 in the same cycle, o_clear SHALL be 1 for exactly one cycle, then o_state=00 with o_run=0; a clear pulse in RUN or RUN_WAIT SHALL produce no o_clear.
REQ-036 With o_lap=1, reset asserted mid-cycle in RUN_WAIT SHALL drop all outputs to 0 immediately, and after release with no pulses o_state SHALL stay 00.
REQ-037 Double click then window expiry: o_lap=1, then a single pulse SHALL cause expiry to STOP with o_lap=0.
